multiply_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point multiplier with valid/ready handshake. Successor to the single-cycle 18x18 Q-format multiplier.
- Operands and result share format Q1.(WDTH-1). Result is the product scaled by >>> (WDTH-1).
- Adds round-half-up, optional saturation with overflow flag, configurable latency, backpressure, and an opaque metadata field carried alongside data.
- Sits between sample-stream blocks (mixers, filters) in the DSP datapath.

---
 rtl/fpgamath_pkg.sv | 23 ++
 rtl/round_sat.sv | 47 ++++
 rtl/multiply_pipe.sv | 144 ++++++++++++++
 tb/tb_multiply_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpgamath_pkg.sv
// Shared fixed-point math helpers for the DSP datapath blocks.
// Contents:
//   MIN_LATENCY    - shortest pipeline supported by the multiplier family
//   round_const(w) - half-LSB constant 2^(w-2) added before the >>> (w-1)
//   sat_max(w)     - largest Q1.(w-1) value,  2^(w-1)-1
//   sat_min(w)     - smallest Q1.(w-1) value, -2^(w-1)
package fpgamath_pkg;

   localparam int MIN_LATENCY = 2;

   function automatic logic signed [63:0] round_const(input int wdth);
      return 64'sd1 <<< (wdth - 2);
   endfunction

   function automatic logic signed [63:0] sat_max(input int wdth);
      return (64'sd1 <<< (wdth - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int wdth);
      return -(64'sd1 <<< (wdth - 1));
   endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational rescale of a full-width Q2.(2*WDTH-2) product back to
// Q1.(WDTH-1): optional round-half-up, arithmetic shift, and either
// saturation or two's-complement wrap on overflow.
// Ports:
//   p_i   in  2*WDTH  signed full product
//   z_o   out WDTH    signed rescaled result
//   ovf_o out 1       result did not fit in WDTH bits (saturated or wrapped)
module round_sat
   import fpgamath_pkg::*;
#(
   parameter int WDTH  = 16,
   parameter int ROUND = 1,
   parameter int SAT   = 1
) (
   input  logic signed [2*WDTH-1:0] p_i,
   output logic signed [WDTH-1:0]   z_o,
   output logic                     ovf_o
);

   localparam logic signed [WDTH-1:0] ZMAX = WDTH'(sat_max(WDTH));
   localparam logic signed [WDTH-1:0] ZMIN = WDTH'(sat_min(WDTH));

   logic signed [2*WDTH-1:0] r;
   logic signed [2*WDTH-1:0] q;
   logic        [WDTH:0]     hi;

   if (ROUND != 0) begin : g_round
      localparam logic signed [2*WDTH-1:0] RC = (2*WDTH)'(round_const(WDTH));
      // Cannot overflow: |P| <= 2^(2*WDTH-2), far below the 2*WDTH-bit limit.
      assign r = p_i + RC;
   end else begin : g_trunc
      assign r = p_i;
   end

   assign q  = r >>> (WDTH - 1);
   // Result fits only if every bit from the WDTH-bit sign upward agrees.
   assign hi = q[2*WDTH-1:WDTH-1];
   assign ovf_o = ~((&hi) | ~(|hi));

   always_comb begin
      z_o = q[WDTH-1:0];
      if ((SAT != 0) && ovf_o) begin
         z_o = q[2*WDTH-1] ? ZMIN : ZMAX;
      end
   end

endmodule

// File: rtl/multiply_pipe.sv
// Pipelined signed Q1.(WDTH-1) multiplier with valid/ready flow control
// and an opaque metadata field that travels with each sample.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   x, y                signed operands
//   in_m                metadata, passed through unchanged
//   out_valid/out_ready output handshake
//   z, out_m, overflow  result, its metadata, and its overflow flag
//
// Handshake: advance = out_ready | ~out_valid drives every stage enable and
// in_ready. A stall freezes the whole pipe (bubbles are not collapsed), so
// each accepted sample exits exactly LATENCY advancing cycles later, in order.
//
// Stage layout: operand stage 1, LATENCY-3 extra operand delay stages (kept
// in front of the multiply so they can be retimed into DSP input registers),
// product register, output register holding rounded/saturated z. With
// LATENCY=2 the product register is omitted and the multiply feeds the
// output register directly.
module multiply_pipe
   import fpgamath_pkg::*;
#(
   parameter int WDTH    = 16,
   parameter int MWDTH   = 1,
   parameter int LATENCY = 3,
   parameter int ROUND   = 1,
   parameter int SAT     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WDTH-1:0]  x,
   input  logic [WDTH-1:0]  y,
   input  logic [MWDTH-1:0] in_m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WDTH-1:0]  z,
   output logic [MWDTH-1:0] out_m,
   output logic             overflow
);

   localparam int NXY = (LATENCY > MIN_LATENCY) ? LATENCY - 2 : 1;
   localparam int NM  = LATENCY - 1;

   logic                     advance;
   logic [LATENCY-1:0]       vld_q;
   logic signed [WDTH-1:0]   x_q [NXY];
   logic signed [WDTH-1:0]   y_q [NXY];
   logic [MWDTH-1:0]         m_q [NM];
   logic signed [2*WDTH-1:0] xw;
   logic signed [2*WDTH-1:0] yw;
   logic signed [2*WDTH-1:0] prod;
   logic signed [WDTH-1:0]   rs_z;
   logic                     rs_ovf;
   logic [WDTH-1:0]          z_q;
   logic [MWDTH-1:0]         out_m_q;
   logic                     ovf_q;

   assign out_valid = vld_q[LATENCY-1];
   assign advance   = out_ready | ~out_valid;
   assign in_ready  = advance;
   assign z         = z_q;
   assign out_m     = out_m_q;
   assign overflow  = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else if (advance) begin
         vld_q <= {vld_q[LATENCY-2:0], in_valid};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NXY; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else if (advance) begin
         x_q[0] <= x;
         y_q[0] <= y;
         for (int i = 1; i < NXY; i++) begin
            x_q[i] <= x_q[i-1];
            y_q[i] <= y_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NM; i++) begin
            m_q[i] <= '0;
         end
      end else if (advance) begin
         m_q[0] <= in_m;
         for (int i = 1; i < NM; i++) begin
            m_q[i] <= m_q[i-1];
         end
      end
   end

   // Sign-extend before multiplying so the full 2*WDTH product is exact.
   assign xw = (2*WDTH)'(x_q[NXY-1]);
   assign yw = (2*WDTH)'(y_q[NXY-1]);

   if (LATENCY > MIN_LATENCY) begin : g_prod_reg
      logic signed [2*WDTH-1:0] p_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            p_q <= '0;
         end else if (advance) begin
            p_q <= xw * yw;
         end
      end
      assign prod = p_q;
   end else begin : g_prod_comb
      assign prod = xw * yw;
   end

   round_sat #(
      .WDTH  (WDTH),
      .ROUND (ROUND),
      .SAT   (SAT)
   ) u_round_sat (
      .p_i   (prod),
      .z_o   (rs_z),
      .ovf_o (rs_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_q     <= '0;
         out_m_q <= '0;
         ovf_q   <= 1'b0;
      end else if (advance) begin
         z_q     <= rs_z;
         out_m_q <= m_q[NM-1];
         ovf_q   <= rs_ovf;
      end
   end

endmodule

// File: tb/tb_multiply_pipe.sv
// Bench for multiply_pipe: instance A uses defaults (WDTH=16, LATENCY=3,
// ROUND=1, SAT=1); instance B uses LATENCY=5, ROUND=0, SAT=0 and only sees
// traffic while A's out_ready is held high. Operands and metadata are shared.
module tb_multiply_pipe;

   localparam int W     = 16;
   localparam int MW    = 4;
   localparam int LAT_A = 3;
   localparam int LAT_B = 5;

   typedef struct {
      logic [W-1:0]  z;
      logic          ovf;
      logic [MW-1:0] m;
      int            cyc;
      bit            chk_lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  x = '0;
   logic [W-1:0]  y = '0;
   logic [MW-1:0] in_m = '0;
   logic          in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic          in_ready_a, in_ready_b;
   logic          out_valid_a, out_valid_b;
   logic          out_ready_a = 1'b1, out_ready_b = 1'b1;
   logic [W-1:0]  z_a, z_b;
   logic [MW-1:0] out_m_a, out_m_b;
   logic          ovf_a, ovf_b;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   bp_mode = 1'b0;
   exp_t exp_a[$];
   exp_t exp_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multiply_pipe #(.WDTH(W), .MWDTH(MW), .LATENCY(LAT_A), .ROUND(1), .SAT(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .x(x), .y(y), .in_m(in_m), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .z(z_a), .out_m(out_m_a), .overflow(ovf_a));

   multiply_pipe #(.WDTH(W), .MWDTH(MW), .LATENCY(LAT_B), .ROUND(0), .SAT(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .x(x), .y(y), .in_m(in_m), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .z(z_b), .out_m(out_m_b), .overflow(ovf_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference for instance A arithmetic (round half up, saturate).
   function automatic logic [W:0] model_a(input logic [W-1:0] xv, input logic [W-1:0] yv);
      longint p;
      longint q;
      p = longint'($signed(xv)) * longint'($signed(yv));
      p = p + 64'sd16384;
      q = p >>> 15;
      if (q > 32767) return {1'b1, 16'h7FFF};
      return {1'b0, q[15:0]};
   endfunction

   // Present one sample; hold it until A accepts it, then push expectations.
   task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [MW-1:0] mv,
                       input logic [W-1:0] za, input logic oa,
                       input logic [W-1:0] zb, input logic ob, input bit use_b);
      int   waited = 0;
      exp_t e;
      @(negedge clk);
      x = xv; y = yv; in_m = mv;
      in_valid_a = 1'b1;
      in_valid_b = use_b;
      if (bp_mode) out_ready_a = 1'($urandom_range(0, 1));
      #1;
      while (!in_ready_a && waited < 50) begin
         @(negedge clk);
         if (bp_mode) out_ready_a = 1'($urandom_range(0, 1));
         #1;
         waited++;
      end
      if (!in_ready_a) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, expected 1", waited);
         in_valid_a = 1'b0;
         in_valid_b = 1'b0;
         return;
      end
      e.z = za; e.ovf = oa; e.m = mv; e.cyc = cyc; e.chk_lat = !bp_mode;
      exp_a.push_back(e);
      if (use_b) begin
         e.z = zb; e.ovf = ob;
         exp_b.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid_a = 1'b0;
         in_valid_b = 1'b0;
         if (bp_mode) out_ready_a = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(exp_a.size() + exp_b.size()), 32'd0);
   endtask

   // Monitor A
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            chk("a_in_ready_rule", {31'd0, in_ready_a}, {31'd0, out_ready_a | ~out_valid_a});
            if (out_valid_a && out_ready_a) begin
               if (exp_a.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL a_unexpected: got output z=%0h, expected no output", z_a);
               end else begin
                  e = exp_a.pop_front();
                  chk("a_z", 32'(z_a), 32'(e.z));
                  chk("a_ovf", 32'(ovf_a), 32'(e.ovf));
                  chk("a_m", 32'(out_m_a), 32'(e.m));
                  if (e.chk_lat) chk("a_latency", 32'(cyc), 32'(e.cyc + LAT_A));
               end
            end
         end
      end
   end

   // Monitor B
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid_b && out_ready_b) begin
            if (exp_b.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL b_unexpected: got output z=%0h, expected no output", z_b);
            end else begin
               e = exp_b.pop_front();
               chk("b_z", 32'(z_b), 32'(e.z));
               chk("b_ovf", 32'(ovf_b), 32'(e.ovf));
               chk("b_m", 32'(out_m_b), 32'(e.m));
               if (e.chk_lat) chk("b_latency", 32'(cyc), 32'(e.cyc + LAT_B));
            end
         end
      end
   end

   initial begin
      logic [W:0] r;
      logic [W-1:0] xv, yv;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
      chk("rst_z_a", 32'(z_a), 32'd0);
      chk("rst_out_m_a", 32'(out_m_a), 32'd0);
      chk("rst_ovf_a", 32'(ovf_a), 32'd0);
      chk("rst_in_ready_a", 32'(in_ready_a), 32'd1);
      chk("rst_out_valid_b", 32'(out_valid_b), 32'd0);
      chk("rst_in_ready_b", 32'(in_ready_b), 32'd1);
      rst_n = 1'b1;

      // Directed vectors: A = round/saturate, B = truncate/wrap
      send(16'h4000, 16'h4000, 4'd1,  16'h2000, 1'b0, 16'h2000, 1'b0, 1'b1);
      send(16'h7FFF, 16'h7FFF, 4'd2,  16'h7FFE, 1'b0, 16'h7FFE, 1'b0, 1'b1);
      send(16'h0001, 16'h4000, 4'd3,  16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
      send(16'hFFFF, 16'h4000, 4'd4,  16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      send(16'h8000, 16'h8000, 4'd5,  16'h7FFF, 1'b1, 16'h8000, 1'b1, 1'b1);
      send(16'h8000, 16'h7FFF, 4'd6,  16'h8001, 1'b0, 16'h8001, 1'b0, 1'b1);
      send(16'h2000, 16'hC000, 4'd7,  16'hF000, 1'b0, 16'hF000, 1'b0, 1'b1);
      send(16'h7FFF, 16'h8000, 4'd8,  16'h8001, 1'b0, 16'h8001, 1'b0, 1'b1);
      send(16'h0001, 16'h0001, 4'd9,  16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
      send(16'h0003, 16'h4000, 4'd10, 16'h0002, 1'b0, 16'h0001, 1'b0, 1'b1);
      idle(2);
      drain();

      // Bubbles: in_valid 1,0,1,1,0 (latency stamps check the delay per sample)
      send(16'h4000, 16'h2000, 4'd11, 16'h1000, 1'b0, 16'h1000, 1'b0, 1'b1);
      idle(1);
      send(16'h2000, 16'h2000, 4'd12, 16'h0800, 1'b0, 16'h0800, 1'b0, 1'b1);
      send(16'hC000, 16'h4000, 4'd13, 16'hE000, 1'b0, 16'hE000, 1'b0, 1'b1);
      idle(1);
      drain();

      // Streaming with random backpressure on A
      bp_mode = 1'b1;
      for (int i = 0; i < 100; i++) begin
         xv = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
         yv = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
         r  = model_a(xv, yv);
         send(xv, yv, 4'(i), r[W-1:0], r[W], 16'h0000, 1'b0, 1'b0);
      end
      idle(1);
      bp_mode = 1'b0;
      @(negedge clk);
      out_ready_a = 1'b1;
      drain();

      // Reset mid-stream with three samples in flight
      send(16'h4000, 16'h4000, 4'd1, 16'h2000, 1'b0, 16'h2000, 1'b0, 1'b1);
      send(16'h7FFF, 16'h7FFF, 4'd2, 16'h7FFE, 1'b0, 16'h7FFE, 1'b0, 1'b1);
      send(16'h8000, 16'h8000, 4'd3, 16'h7FFF, 1'b1, 16'h8000, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      #1;
      chk("midrst_out_valid_a", 32'(out_valid_a), 32'd0);
      chk("midrst_z_a", 32'(z_a), 32'd0);
      chk("midrst_out_m_a", 32'(out_m_a), 32'd0);
      chk("midrst_ovf_a", 32'(ovf_a), 32'd0);
      chk("midrst_in_ready_a", 32'(in_ready_a), 32'd1);
      chk("midrst_out_valid_b", 32'(out_valid_b), 32'd0);
      exp_a.delete();
      exp_b.delete();
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      idle(10);
      #1;
      chk("postrst_quiet_a", 32'(out_valid_a), 32'd0);
      chk("postrst_quiet_b", 32'(out_valid_b), 32'd0);
      send(16'h4000, 16'h4000, 4'd5, 16'h2000, 1'b0, 16'h2000, 1'b0, 1'b1);
      idle(1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule
